// File: rtl/rtc_bus_arbiter_if.sv
// rtl/rtc_bus_arbiter_if.sv - requester and transaction-engine signals of the RTC bus arbiter
// master = requesters plus engine side, slave = the arbiter itself.
interface rtc_bus_arbiter_if;
  logic [2:0] req;
  logic [2:0] wr_req;
  logic [7:0] addr0;
  logic [7:0] addr1;
  logic [7:0] addr2;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [7:0] wdata2;
  logic       timeout_clr;
  logic [2:0] gnt;
  logic [2:0] done;
  logic       err;
  logic [7:0] rdata;
  logic       timeout;
  logic       eng_start;
  logic       eng_write;
  logic [7:0] eng_addr;
  logic [7:0] eng_wdata;
  logic       eng_done;
  logic [7:0] eng_rdata;

  modport master (
    output req, wr_req, addr0, addr1, addr2, wdata0, wdata1, wdata2, timeout_clr,
    output eng_done, eng_rdata,
    input  gnt, done, err, rdata, timeout,
    input  eng_start, eng_write, eng_addr, eng_wdata
  );

  modport slave (
    input  req, wr_req, addr0, addr1, addr2, wdata0, wdata1, wdata2, timeout_clr,
    input  eng_done, eng_rdata,
    output gnt, done, err, rdata, timeout,
    output eng_start, eng_write, eng_addr, eng_wdata
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - three-way arbiter in front of the RTC parallel-bus transaction engine
// Requester 0 has fixed priority; 1 and 2 alternate. Every output is a register.
module rtc_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int GAP_CYCLES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  rtc_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT_CYCLES);
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_t     state, state_d;
  logic [1:0] idx, idx_d;
  logic       rr_favor2, rr_favor2_d;
  logic [7:0] wdog, wdog_d;
  logic [3:0] gap_cnt, gap_cnt_d;
  logic [2:0] gnt_q, gnt_d;
  logic [2:0] done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       timeout_q, timeout_d;
  logic       start_q, start_d;
  logic       write_q, write_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       have_win;
  logic [1:0] win;
  logic       abort;
  logic       finish;
  logic [8:0] wdog_inc;

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    rr_favor2_d = rr_favor2;
    wdog_d      = wdog;
    gap_cnt_d   = gap_cnt;
    gnt_d       = gnt_q;
    done_d      = 3'b000;
    err_d       = 1'b0;
    rdata_d     = rdata_q;
    start_d     = 1'b0;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    have_win    = 1'b0;
    win         = 2'd0;
    abort       = 1'b0;
    finish      = 1'b0;
    wdog_inc    = {1'b0, wdog} + 9'd1;

    case (state)
      IDLE: begin
        if (bus.req[0]) begin
          have_win = 1'b1;
          win      = 2'd0;
        end else if (bus.req[1] && bus.req[2]) begin
          have_win = 1'b1;
          win      = rr_favor2 ? 2'd2 : 2'd1;
        end else if (bus.req[1]) begin
          have_win = 1'b1;
          win      = 2'd1;
        end else if (bus.req[2]) begin
          have_win = 1'b1;
          win      = 2'd2;
        end
        if (have_win) begin
          idx_d   = win;
          gnt_d   = onehot(win);
          start_d = 1'b1;
          write_d = bus.wr_req[win];
          case (win)
            2'd0:    begin addr_d = bus.addr0; wdata_d = bus.wdata0; end
            2'd1:    begin addr_d = bus.addr1; wdata_d = bus.wdata1; end
            default: begin addr_d = bus.addr2; wdata_d = bus.wdata2; end
          endcase
          // Pointer only moves between the two round-robin requesters.
          if (win == 2'd1) rr_favor2_d = 1'b1;
          if (win == 2'd2) rr_favor2_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        wdog_d  = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_inc[7:0];
        // A completion on the limit cycle still wins over the abort.
        if (bus.eng_done) begin
          done_d = onehot(idx);
          if (!write_q) rdata_d = bus.eng_rdata;
          gnt_d  = 3'b000;
          finish = 1'b1;
        end else if (wdog_inc == TO_LIMIT) begin
          done_d  = onehot(idx);
          err_d   = 1'b1;
          rdata_d = 8'h00;
          gnt_d   = 3'b000;
          abort   = 1'b1;
          finish  = 1'b1;
        end
        if (finish) begin
          gap_cnt_d = 4'd0;
          state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_d = IDLE;
        else                     gap_cnt_d = gap_cnt + 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (abort)                timeout_d = 1'b1;
    else if (bus.timeout_clr) timeout_d = 1'b0;
    else                      timeout_d = timeout_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 2'd0;
      rr_favor2 <= 1'b0;
      wdog      <= 8'd0;
      gap_cnt   <= 4'd0;
      gnt_q     <= 3'b000;
      done_q    <= 3'b000;
      err_q     <= 1'b0;
      rdata_q   <= 8'h00;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      rr_favor2 <= rr_favor2_d;
      wdog      <= wdog_d;
      gap_cnt   <= gap_cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.timeout   = timeout_q;
  assign bus.eng_start = start_q;
  assign bus.eng_write = write_q;
  assign bus.eng_addr  = addr_q;
  assign bus.eng_wdata = wdata_q;
endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Shares the single RTC parallel-bus transaction engine (start/write/address/data in, done/read-data out; drives CS/AD/RD/WR) between three requesters.
- Requester 0 is the power-up initialisation sequencer, requester 1 is the user-edit path, and requester 2 is the periodic time/date poller.
- Serialises one bus transaction at a time, enforces a bus-recovery gap, and aborts hung transactions with a watchdog.

Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT-state cycles before a transaction is aborted (1..255).
- GAP_CYCLES, 2: idle cycles inserted after every transaction before the next arbitration (0..15).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  3  per-requester request; bit i belongs to requester i.
- wr_req  in  3  per-requester direction; 1 = write, 0 = read.
- addr0, addr1, addr2  in  8 each  RTC register address of requester 0/1/2.
- wdata0, wdata1, wdata2  in  8 each  write data of requester 0/1/2.
- timeout_clr  in  1  clears the sticky timeout flag.
- gnt  out  3  one-hot grant, held for the whole transaction.
- done  out  3  one-cycle completion pulse to the granted requester.
- err  out  1  high together with done when the transaction timed out.
- rdata  out  8  read data, valid while done is high.
- timeout  out  1  sticky flag, set on any abort.
- eng_start  out  1  one-cycle start pulse to the transaction engine.
- eng_write  out  1  latched direction.
- eng_addr  out  8  latched address.
- eng_wdata  out  8  latched write data.
- eng_done  in  1  engine completion pulse.
- eng_rdata  in  8  engine read data, valid with eng_done.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer = requester 1, timers 0.
- Reset mid-transaction returns to IDLE immediately. No done pulse is issued. The engine's own reset handles the bus.
- Every output is registered.

State machine, IDLE -> START -> WAIT -> GAP -> IDLE:
- IDLE:
  - req is sampled only in this state.
  - Priority: req[0] always wins. Between req[1] and req[2], round-robin: the pointer favours the requester not served last. After serving 1 the pointer moves to 2, and vice versa. Serving 0 leaves the pointer unchanged.
  - Winner selected at edge N: its index, addr, wdata and wr_req are latched; gnt[idx] = 1 and eng_start = 1 during cycle N+1 (START).
  - No req: stay in IDLE.
- START:
  - Exactly one cycle with eng_start high; eng_addr, eng_wdata and eng_write are stable from here until the next grant.
  - Next state WAIT; watchdog counter cleared.
  - eng_done during START is ignored.
- WAIT:
  - The watchdog counter increments each cycle.
  - If eng_done is seen at cycle M: at M+1, done[idx] = 1, rdata = eng_rdata (reads only; rdata holds its previous value on writes), err = 0, gnt = 0, then go to GAP.
  - If the counter reaches TIMEOUT_CYCLES without eng_done: next cycle, done[idx] = 1, err = 1, rdata = 0x00, timeout = 1, gnt = 0, then go to GAP.
  - eng_done arriving in the same cycle the limit is reached counts as success.
- GAP:
  - Counts GAP_CYCLES cycles, then returns to IDLE.
  - With GAP_CYCLES = 0, WAIT goes directly to IDLE.
  - req is ignored throughout GAP.
- Requester protocol:
  - Hold req and operands until done.
  - Dropping req after the grant does not cancel the transaction.
  - req still high in IDLE after done is treated as a new request.
- timeout flag: cleared by timeout_clr when no abort occurs in the same cycle. A simultaneous abort and timeout_clr leaves it set.
- eng_done outside WAIT is ignored and produces no done pulse.
- Minimum transaction period, with the engine responding in its first WAIT cycle: 1 (IDLE) + 1 (START) + 1 (WAIT) + GAP_CYCLES.

Test Plan:
- Reset, then req = 3'b001, wr_req[0] = 1, addr0 = 0x11, wdata0 = 0x40; engine answers eng_done 5 cycles after eng_start -> gnt = 001 one cycle after req, single eng_start, eng_addr/eng_wdata = 0x11/0x40, done = 001 one cycle after eng_done, err = 0.
- req = 3'b111 held continuously, GAP_CYCLES = 2 -> service order 0, 0, … while req[0] is held. Then drop req[0] -> order 1, 2, 1, 2. Consecutive eng_start pulses are separated by at least the WAIT length plus 3 cycles.
- Read by requester 2 with eng_rdata = 0x59 alongside eng_done -> rdata = 0x59 in the same cycle as done = 100.
- Engine never answers, TIMEOUT_CYCLES = 8 -> done with err = 1, rdata = 0x00, timeout = 1 and held; a timeout_clr pulse clears it; the next request is served normally.
- Assert reset during WAIT -> next cycle gnt = 0, done = 0, eng_start = 0, state IDLE; a spurious eng_done afterwards produces no done pulse.
- eng_done pulsed during START plus a req[1] drop after grant -> transaction still waits for a WAIT-state eng_done and completes with done = 010.
